ln_scheduler: RTL and testbench



---
 rtl/ln_sched_pkg.sv | 10 +
 rtl/ln_scheduler_if.sv | 28 ++
 rtl/ln_rr_arbiter.sv | 18 +
 rtl/ln_scheduler.sv | 77 +++++++
 tb/tb_ln_scheduler.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/ln_sched_pkg.sv
// ln_sched_pkg: FSM state type and sizing helpers for the LayerNorm scheduler.
package ln_sched_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  function automatic int timer_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ln_scheduler_if.sv
// ln_scheduler_if: requester, response and engine-control signals of ln_scheduler.
interface ln_scheduler_if import ln_sched_pkg::*; #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 8,
  parameter int PSEL_W = 2
);
  localparam int OWN_W = idx_w(NREQ);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*PSEL_W-1:0] req_psel;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        rsp_valid;
  logic                   rsp_err;
  logic                   eng_start;
  logic [ADDR_W-1:0]      eng_addr;
  logic [PSEL_W-1:0]      eng_psel;
  logic                   eng_done;
  logic                   busy;
  logic [OWN_W-1:0]       owner;
  modport slave (
    input  req_valid, req_addr, req_psel, eng_done,
    output req_ready, rsp_valid, rsp_err, eng_start, eng_addr, eng_psel, busy, owner
  );
  modport master (
    output req_valid, req_addr, req_psel, eng_done,
    input  req_ready, rsp_valid, rsp_err, eng_start, eng_addr, eng_psel, busy, owner
  );
endinterface

// File: rtl/ln_rr_arbiter.sv
// ln_rr_arbiter: combinational round-robin pick, searching upward from i_ptr with wrap.
module ln_rr_arbiter import ln_sched_pkg::*; #(
  parameter int NREQ = 2,
  localparam int OWN_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [OWN_W-1:0] i_ptr,
  output logic [OWN_W-1:0] o_grant_idx,
  output logic             o_any_req
);
  // Scan farthest-first so the last hit, the one nearest the pointer, wins.
  always_comb begin
    o_grant_idx = i_ptr;
    o_any_req = |i_req;
    for (int i = NREQ - 1; i >= 0; i--)
      if (i_req[(int'(i_ptr) + i) % NREQ]) o_grant_idx = OWN_W'((int'(i_ptr) + i) % NREQ);
  end
endmodule

// File: rtl/ln_scheduler.sv
// ln_scheduler: round-robin sharing of one LayerNorm engine among NREQ requesters,
// one job at a time, with a watchdog that forces an error response.
module ln_scheduler import ln_sched_pkg::*; #(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 8,
  parameter int PSEL_W  = 2,
  parameter int TIMEOUT = 64
) (
  input logic           clk,
  input logic           rst,
  ln_scheduler_if.slave bus
);
  localparam int OWN_W   = idx_w(NREQ);
  localparam int TIMER_W = timer_w(TIMEOUT);
  state_t              r_state, w_next;
  logic [TIMER_W-1:0]  r_timer;
  logic [OWN_W-1:0]    r_owner, r_ptr, w_grant;
  logic                w_any, w_fin;
  logic [ADDR_W-1:0]   r_addr;
  logic [PSEL_W-1:0]   r_psel;
  logic [NREQ-1:0]     r_req_ready, r_rsp_valid;
  logic                r_rsp_err, r_eng_start, r_busy;

  ln_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req      (bus.req_valid),
    .i_ptr      (r_ptr),
    .o_grant_idx(w_grant),
    .o_any_req  (w_any)
  );

  always_comb begin
    w_fin = bus.eng_done || r_timer == TIMER_W'(TIMEOUT - 1);
    w_next = (r_state == IDLE)  ? (w_any ? ISSUE : IDLE) :
             (r_state == ISSUE) ? WAIT :
             (r_state == WAIT)  ? (w_fin ? RESP : WAIT) : IDLE;
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_owner     <= '0;
      r_ptr       <= '0;
      r_addr      <= '0;
      r_psel      <= '0;
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      r_rsp_err   <= 1'b0;
      r_eng_start <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_timer <= (r_state == ISSUE) ? '0 : (r_state == WAIT) ? r_timer + TIMER_W'(1) : r_timer;
      if (r_state == IDLE && w_any) begin
        r_owner <= w_grant;
        r_addr  <= bus.req_addr[int'(w_grant)*ADDR_W +: ADDR_W];
        r_psel  <= bus.req_psel[int'(w_grant)*PSEL_W +: PSEL_W];
      end
      if (r_state == RESP) r_ptr <= (int'(r_owner) == NREQ - 1) ? '0 : r_owner + 1'b1;
      r_eng_start <= w_next == ISSUE;
      r_req_ready <= (w_next == ISSUE) ? NREQ'(1) << w_grant : '0;
      r_rsp_valid <= (w_next == RESP) ? NREQ'(1) << r_owner : '0;
      r_rsp_err   <= w_next == RESP && !bus.eng_done;
      r_busy      <= w_next != IDLE;
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.eng_start = r_eng_start;
  assign bus.eng_addr  = r_addr;
  assign bus.eng_psel  = r_psel;
  assign bus.busy      = r_busy;
  assign bus.owner     = r_owner;
endmodule

// File: tb/tb_ln_scheduler.sv
// tb_ln_scheduler: randomized job-level checks of ln_scheduler (NREQ=2, TIMEOUT=8)
// against a transaction model of round-robin grant order and response timing.
module tb_ln_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vecs = 0;
  int errs = 0;
  int m_ptr = 0;

  ln_scheduler_if #(.NREQ(2), .ADDR_W(8), .PSEL_W(2)) bus ();
  ln_scheduler #(.NREQ(2), .ADDR_W(8), .PSEL_W(2), .TIMEOUT(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.eng_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    vecs++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.eng_start, bus.eng_addr, bus.eng_psel, bus.busy, bus.owner} !== 18'd0) begin
      errs++;
      $display("FAIL reset: ready=%b rsp=%b err=%b start=%b addr=%h psel=%h busy=%b owner=%b, expected all zero",
               bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.eng_start, bus.eng_addr, bus.eng_psel, bus.busy, bus.owner);
    end
    m_ptr = 0;
  endtask

  // One full job from an IDLE cycle: lat in 1..8 pulses eng_done lat cycles after start,
  // anything else lets the watchdog fire. Returns in the IDLE cycle after the response.
  task automatic do_job(input logic [1:0] reqs, input logic [15:0] addrs, input logic [3:0] psels,
                        input int lat, input bit stale, output int w);
    int fin;
    logic err;
    logic [7:0] ea;
    logic [1:0] ep;
    w = -1;
    for (int i = 0; i < 2; i++) if (w < 0 && reqs[(m_ptr + i) % 2]) w = (m_ptr + i) % 2;
    err = !(lat >= 1 && lat <= 8);
    fin = err ? 9 : lat + 1;
    ea = addrs[w*8 +: 8];
    ep = psels[w*2 +: 2];
    bus.req_valid = reqs;
    bus.req_addr = addrs;
    bus.req_psel = psels;
    tick();
    vecs++;
    if ({bus.eng_start, bus.req_ready, bus.eng_addr, bus.eng_psel, bus.owner, bus.busy} !== {1'b1, 2'(1 << w), ea, ep, 1'(w), 1'b1}) begin
      errs++;
      $display("FAIL issue: start=%b ready=%b addr=%h psel=%h owner=%b busy=%b, expected start=1 ready=%b addr=%h psel=%h owner=%0d busy=1",
               bus.eng_start, bus.req_ready, bus.eng_addr, bus.eng_psel, bus.owner, bus.busy, 2'(1 << w), ea, ep, w);
    end
    bus.req_valid[w] = 1'b0;
    for (int c = 1; c < fin; c++) begin
      tick();
      bus.eng_done = (c == lat);
      vecs++;
      if ({bus.rsp_valid, bus.busy, bus.eng_start, bus.req_ready} !== 6'b001000) begin
        errs++;
        $display("FAIL wait c=%0d: rsp=%b busy=%b start=%b ready=%b, expected rsp=00 busy=1 start=0 ready=00",
                 c, bus.rsp_valid, bus.busy, bus.eng_start, bus.req_ready);
      end
    end
    tick();
    bus.eng_done = stale;
    vecs++;
    if ({bus.rsp_valid, bus.rsp_err, bus.busy, bus.owner} !== {2'(1 << w), err, 1'b1, 1'(w)}) begin
      errs++;
      $display("FAIL resp: rsp=%b err=%b busy=%b owner=%b, expected rsp=%b err=%b busy=1 owner=%0d",
               bus.rsp_valid, bus.rsp_err, bus.busy, bus.owner, 2'(1 << w), err, w);
    end
    m_ptr = (w + 1) % 2;
    tick();
    bus.eng_done = 1'b0;
    vecs++;
    if ({bus.busy, bus.rsp_valid, bus.eng_start} !== 4'b0000) begin
      errs++;
      $display("FAIL idle: busy=%b rsp=%b start=%b, expected all zero", bus.busy, bus.rsp_valid, bus.eng_start);
    end
  endtask

  task automatic test_single();
    int w;
    do_job(2'b01, {8'h00, 8'd5}, {2'd0, 2'd1}, 4, 1'b0, w);
  endtask

  task automatic test_fairness();
    int g[4];
    test_reset();
    for (int i = 0; i < 4; i++) do_job(2'b11, 16'($urandom), 4'($urandom), 2, 1'b0, g[i]);
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (g[i] !== i % 2) begin
        errs++;
        $display("FAIL fairness grant %0d: got %0d, expected %0d", i, g[i], i % 2);
      end
    end
  endtask

  task automatic test_timeout();
    int w;
    do_job(2'b10, 16'($urandom), 4'($urandom), 0, 1'b0, w);
    do_job(2'b01, 16'($urandom), 4'($urandom), 3, 1'b0, w);
  endtask

  task automatic test_collision();
    int w;
    do_job(2'b11, 16'($urandom), 4'($urandom), 8, 1'b0, w);
  endtask

  task automatic test_stale();
    int w;
    bus.req_valid = '0;
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vecs++;
      if ({bus.busy, bus.rsp_valid, bus.eng_start, bus.req_ready} !== 6'd0) begin
        errs++;
        $display("FAIL stale idle: busy=%b rsp=%b start=%b ready=%b, expected all zero",
                 bus.busy, bus.rsp_valid, bus.eng_start, bus.req_ready);
      end
      tick();
    end
    do_job(2'b01, 16'($urandom), 4'($urandom), 3, 1'b1, w);
    do_job(2'b11, 16'($urandom), 4'($urandom), 2, 1'b0, w);
  endtask

  task automatic test_reset_mid();
    int w;
    do_job(2'b01, 16'($urandom), 4'($urandom), 2, 1'b0, w);
    bus.req_valid = 2'b01;
    bus.req_addr = 16'hA5C3;
    bus.req_psel = 4'b1110;
    tick();
    vecs++;
    if ({bus.eng_start, bus.owner} !== 2'b10) begin
      errs++;
      $display("FAIL mid start: start=%b owner=%b, expected start=1 owner=0", bus.eng_start, bus.owner);
    end
    bus.req_valid = '0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vecs++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.eng_start, bus.eng_addr, bus.eng_psel, bus.busy, bus.owner} !== 18'd0) begin
      errs++;
      $display("FAIL mid reset: ready=%b rsp=%b err=%b start=%b addr=%h psel=%h busy=%b owner=%b, expected all zero",
               bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.eng_start, bus.eng_addr, bus.eng_psel, bus.busy, bus.owner);
    end
    m_ptr = 0;
    tick();
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    vecs++;
    if ({bus.rsp_valid, bus.busy, bus.eng_start} !== 4'b0000) begin
      errs++;
      $display("FAIL late done: rsp=%b busy=%b start=%b, expected all zero", bus.rsp_valid, bus.busy, bus.eng_start);
    end
    do_job(2'b11, 16'($urandom), 4'($urandom), 1, 1'b0, w);
    do_job(2'b10, 16'($urandom), 4'($urandom), 5, 1'b0, w);
  endtask

  task automatic test_random();
    int w;
    for (int n = 0; n < 30; n++)
      do_job(2'($urandom_range(1, 3)), 16'($urandom), 4'($urandom), $urandom_range(0, 11), 1'($urandom_range(0, 1)), w);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.req_psel = '0;
    bus.eng_done = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_collision();
    test_stale();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
